keypad_press_ctrl: RTL and testbench
====================================

# keypad_press_ctrl

Parametrised keypad front end that scans a ROWS×COLS matrix, debounces press and release, and reports one key event per press, with optional auto-repeat. It supersedes the fixed 4×4 press FSM: it owns column scanning, input synchronisation and the debounce counter instead of relying on an external debouncer. It sits between the keypad pins and the key-code consumer (display/decoder logic).

## Interface
- `ROWS`, default 4: number of row inputs, ≥2.
- `COLS`, default 4: number of column drives, ≥2.
- `SCAN_DWELL`, default 16: cycles each column is driven while scanning; must be ≥3.
- `DEBOUNCE_CYCLES`, default 50000: cycles a level must be stable to count as a press or release; must be ≥2.
- `REPEAT_EN`, default 0: 1 enables auto-repeat while a key is held.
- `REPEAT_DELAY`, default 500000: HOLD cycles before the first repeat event.
- `REPEAT_PERIOD`, default 100000: cycles between subsequent repeat events.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `rows`, in, ROWS: raw asynchronous row sense; 1 = pressed.
- `col_drive`, out, COLS: one-hot active column.
- `key_row`, out, $clog2(ROWS): captured row index.
- `key_col`, out, $clog2(COLS): captured column index.
- `key_valid`, out, 1: one-cycle key event strobe.
- `key_repeat`, out, 1: qualifies `key_valid`; 1 = auto-repeat event.
- `key_release`, out, 1: one-cycle strobe on a debounced release.
- `key_held`, out, 1: state is HOLD or RELEASE.
- `state`, out, 2: current state encoding.

## Operation
- `rows` passes through a 2-flop synchroniser to give `rows_s`. All decisions use `rows_s`.
- One shared counter `cnt` covers dwell, debounce and repeat timing. It is cleared on every state change.

States:
- **SCAN (0)**
  - `col_drive` holds for SCAN_DWELL cycles. At the last dwell cycle `rows_s` is evaluated.
  - If `rows_s` is onehot: capture the row index and current column index, go to DEBOUNCE, and freeze `col_drive`.
  - If `rows_s` is zero or multi-hot (ghost/chord): reject and rotate the column (COLS-1 wraps to 0).
- **DEBOUNCE (1)**
  - If `rows_s` ≠ captured onehot (any difference): go to SCAN on the same column with dwell restarted. No event.
  - If it matches for DEBOUNCE_CYCLES consecutive cycles: go to HOLD.
- **HOLD (2)**
  - Only the captured row bit matters; other row bits are ignored.
  - If the captured bit is 0: go to RELEASE.
  - If REPEAT_EN: emit a repeat event at HOLD cycle REPEAT_DELAY (cycle index from 0), then every REPEAT_PERIOD cycles.
- **RELEASE (3)**
  - If the captured bit returns to 1 before DEBOUNCE_CYCLES cycles: go back to HOLD. No new `key_valid`; the repeat timer restarts from 0.
  - After DEBOUNCE_CYCLES consecutive cycles with the bit at 0: assert `key_release`, go to SCAN, and rotate to the next column.

Outputs:
- `key_row`/`key_col` update only on capture. They stay stable through HOLD/RELEASE and after release until the next capture.
- Counter width is $clog2(max of all timing params + 1). No wrap occurs: the counter is cleared before reaching its maximum.

## Timing
- All outputs are registered.
- Reset values: `col_drive` = 1 (column 0); `key_row`, `key_col`, `key_valid`, `key_repeat`, `key_release`, `key_held` = 0; `state` = 0 (SCAN); `cnt` = 0; synchroniser flops = 0.
- `key_valid` = 1 for exactly one cycle: the first HOLD cycle entered from DEBOUNCE, with `key_repeat` = 0.
- Repeat events pulse `key_valid` and `key_repeat` together for one cycle.
- DEBOUNCE lasts exactly DEBOUNCE_CYCLES cycles on success.
- Latency from a stable press at the pins to `key_valid`: 2 sync cycles + remaining dwell + DEBOUNCE_CYCLES + 1.
- `key_release` is asserted in the first SCAN cycle after RELEASE completes. `key_held` is 0 in that cycle.
- Reset asserted mid-operation returns to reset values on the next edge, and no strobe is emitted on that edge.
- Simultaneous events resolve by state:
  - In DEBOUNCE, a mismatch on the final count cycle wins (back to SCAN).
  - In HOLD, release wins over a repeat event due that cycle.

## Structure
- `keypad_pkg` holds:
  - `state_t` enum (SCAN, DEBOUNCE, HOLD, RELEASE = 2'd0..3)
  - default timing constants
  - an `onehot_index` function returning the index of a onehot vector
- Sub-module `sync_2ff` (parameter WIDTH) synchronises `rows`. The counter and FSM stay in `keypad_press_ctrl`.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DWELL=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=10.

- **Clean press:** row 2 high while `col_drive`=4'b0100 → one `key_valid` with `key_row`=2, `key_col`=2, `key_repeat`=0; `key_held`=1 until release; `key_release` 8 cycles after the synced release.
- **Bounce:** row toggles every 3 cycles during DEBOUNCE → return to SCAN, no `key_valid`; after stable 8 cycles → exactly one `key_valid`.
- **Ghost/chord:** rows=4'b0011 at dwell end → no capture and the column rotates; `state` stays 0.
- **Auto-repeat (REPEAT_EN=1), 45-cycle hold:** `key_valid` at HOLD cycles 0, 20, 30, 40; `key_repeat` = 0, 1, 1, 1. With REPEAT_EN=0: only cycle 0.
- **Release glitch:** row low for 5 cycles then high → back to HOLD, no `key_valid`, no `key_release`.
- **Reset mid-HOLD:** `reset` pulsed → next cycle `state`=0, `col_drive`=4'b0001, all strobes 0; no `key_release` emitted.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, default timing and helpers for the keypad scan/debounce front end.
// Pure declarations: no logic, no latency, no flow control.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int DEF_ROWS            = 4;
    localparam int DEF_COLS            = 4;
    localparam int DEF_SCAN_DWELL      = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_REPEAT_EN       = 0;
    localparam int DEF_REPEAT_DELAY    = 500000;
    localparam int DEF_REPEAT_PERIOD   = 100000;

    // Index of the set bit; OR-reduction of indices is exact for a onehot input.
    function automatic int onehot_index(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_press_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous row sense lines.
// Latency 2 cycles; free-running, no backpressure.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_press_ctrl.sv
// Keypad matrix scanner with debounce, single press event, optional auto-repeat.
// Press-to-event latency 2 + remaining dwell + DEBOUNCE_CYCLES + 1; strobes only, no backpressure.
module keypad_press_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS            = DEF_ROWS,
    parameter int COLS            = DEF_COLS,
    parameter int SCAN_DWELL      = DEF_SCAN_DWELL,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ROWS-1:0]         rows,
    output logic [COLS-1:0]         col_drive,
    output logic [$clog2(ROWS)-1:0] key_row,
    output logic [$clog2(COLS)-1:0] key_col,
    output logic                    key_valid,
    output logic                    key_repeat,
    output logic                    key_release,
    output logic                    key_held,
    output logic [1:0]              state
);

    localparam int RW   = $clog2(ROWS);
    localparam int CLW  = $clog2(COLS);
    localparam int T1   = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
    localparam int T2   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMAX = (T1 > T2) ? T1 : T2;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DWELL_LAST  = CW'(SCAN_DWELL - 1);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    state_t          st;
    logic [CW-1:0]   cnt;
    logic [CLW-1:0]  col_idx;
    logic [CLW-1:0]  col_next;
    logic [COLS-1:0] col_next_oh;
    logic [ROWS-1:0] rows_s;
    logic [ROWS-1:0] cap_rows;
    logic [31:0]     rows_ext;
    logic            rows_onehot;
    logic            cap_hit;
    logic            rep_periodic;
    logic [CW-1:0]   rep_last;

    sync_2ff #(.WIDTH(ROWS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    assign rows_ext    = 32'(rows_s);
    assign rows_onehot = (rows_s != '0) && ((rows_s & (rows_s - ROWS'(1))) == '0);
    // In HOLD/RELEASE only the captured row matters; chords on other rows are ignored.
    assign cap_hit     = |(rows_s & cap_rows);
    assign col_next    = (col_idx == CLW'(COLS - 1)) ? '0 : col_idx + CLW'(1);
    assign col_next_oh = COLS'(1) << col_next;
    assign rep_last    = rep_periodic ? PERIOD_LAST : DELAY_LAST;
    assign state       = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= SCAN;
            cnt          <= '0;
            col_idx      <= '0;
            col_drive    <= COLS'(1);
            cap_rows     <= '0;
            key_row      <= '0;
            key_col      <= '0;
            key_valid    <= 1'b0;
            key_repeat   <= 1'b0;
            key_release  <= 1'b0;
            key_held     <= 1'b0;
            rep_periodic <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_repeat  <= 1'b0;
            key_release <= 1'b0;
            unique case (st)
                SCAN: begin
                    if (cnt == DWELL_LAST) begin
                        cnt <= '0;
                        if (rows_onehot) begin
                            st       <= DEBOUNCE;
                            cap_rows <= rows_s;
                            key_row  <= RW'(onehot_index(rows_ext));
                            key_col  <= col_idx;
                        end else begin
                            col_idx   <= col_next;
                            col_drive <= col_next_oh;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DEBOUNCE: begin
                    // Mismatch is tested first so it beats completion on the last count.
                    if (rows_s != cap_rows) begin
                        st  <= SCAN;
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        st           <= HOLD;
                        cnt          <= '0;
                        key_valid    <= 1'b1;
                        key_held     <= 1'b1;
                        rep_periodic <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (!cap_hit) begin
                        st  <= RELEASE;
                        cnt <= '0;
                    end else if (REPEAT_EN != 0) begin
                        // Strobe is registered, so fire one cycle early to land on the due cycle.
                        if (cnt == rep_last) begin
                            cnt          <= '0;
                            key_valid    <= 1'b1;
                            key_repeat   <= 1'b1;
                            rep_periodic <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (cap_hit) begin
                        st           <= HOLD;
                        cnt          <= '0;
                        rep_periodic <= 1'b0;
                    end else if (cnt == DEB_LAST) begin
                        st          <= SCAN;
                        cnt         <= '0;
                        key_release <= 1'b1;
                        key_held    <= 1'b0;
                        col_idx     <= col_next;
                        col_drive   <= col_next_oh;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_press_ctrl.sv
// Directed bench: two instances (repeat on/off) driven in lockstep, immediate-assert checks.
module tb_keypad_press_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;

    logic [3:0] col1, col0;
    logic [1:0] row1, row0, kc1, kc0, st1, st0;
    logic       kv1, kv0, krp1, krp0, krl1, krl0, kh1, kh0;

    int checks   = 0;
    int failures = 0;
    int vc1 = 0, vc0 = 0, rc1 = 0, rc0 = 0;
    int n;
    int base_v1, base_v0, base_r1;
    logic exp_ev;

    always #5 clk = ~clk;

    keypad_press_ctrl #(
        .ROWS(4), .COLS(4), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(8),
        .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
    ) u_dut (
        .clk(clk), .reset(reset), .rows(rows), .col_drive(col1),
        .key_row(row1), .key_col(kc1), .key_valid(kv1), .key_repeat(krp1),
        .key_release(krl1), .key_held(kh1), .state(st1)
    );

    keypad_press_ctrl #(
        .ROWS(4), .COLS(4), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(8),
        .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
    ) u_dut0 (
        .clk(clk), .reset(reset), .rows(rows), .col_drive(col0),
        .key_row(row0), .key_col(kc0), .key_valid(kv0), .key_repeat(krp0),
        .key_release(krl0), .key_held(kh0), .state(st0)
    );

    always @(posedge clk) begin
        if (kv1 === 1'b1)  vc1 <= vc1 + 1;
        if (kv0 === 1'b1)  vc0 <= vc0 + 1;
        if (krl1 === 1'b1) rc1 <= rc1 + 1;
        if (krl0 === 1'b1) rc0 <= rc0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns at the first cycle in which col1 shows column c.
    task automatic wait_col(input logic [3:0] c);
        int k;
        k = 0;
        while (col1 === c && k < 100) begin @(negedge clk); k++; end
        while (col1 !== c && k < 200) begin @(negedge clk); k++; end
        chk("wait_col_reached", {31'b0, col1 === c}, 32'd1);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (kv1 !== 1'b1 && cyc < 60);
    endtask

    task automatic wait_rel(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (krl1 !== 1'b1 && cyc < 60);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rows  = 4'b0000;
        reset = 1'b1;
        step(3);
        chk("rst_state",   st1,  0);
        chk("rst_col",     col1, 4'b0001);
        chk("rst_valid",   kv1,  0);
        chk("rst_release", krl1, 0);
        chk("rst_held",    kh1,  0);
        chk("rst_row",     row1, 0);
        chk("rst_kcol",    kc1,  0);
        chk("rst_repeat",  krp1, 0);
        reset = 1'b0;

        // Clean press on row 2 / column 2
        base_v1 = vc1; base_r1 = rc1;
        wait_col(4'b0100);
        rows = 4'b0100;
        wait_valid(n);
        chk("press_latency", n, 12);
        chk("press_row",     row1, 2);
        chk("press_col",     kc1,  2);
        chk("press_repeat",  krp1, 0);
        chk("press_held",    kh1,  1);
        chk("press_state",   st1,  2);
        chk("press_valid_norep", kv0, 1);
        step(1);
        chk("press_one_shot", kv1, 0);
        chk("press_held_on",  kh1, 1);
        step(3);
        rows = 4'b0000;
        wait_rel(n);
        chk("release_latency", n, 11);
        chk("release_held",    kh1, 0);
        chk("release_state",   st1, 0);
        chk("release_rotate",  col1, 4'b1000);
        chk("release_row_kept", row1, 2);
        step(1);
        chk("release_one_shot", krl1, 0);
        chk("press_valid_count",   vc1 - base_v1, 1);
        chk("press_release_count", rc1 - base_r1, 1);

        // Bounce during debounce, then settle
        base_v1 = vc1;
        wait_col(4'b0100);
        rows = 4'b0100;
        step(4);
        chk("bounce_in_deb1", st1, 1);
        rows = 4'b0000;
        step(3);
        chk("bounce_back_scan1", st1, 0);
        chk("bounce_same_col1",  col1, 4'b0100);
        rows = 4'b0100;
        step(4);
        chk("bounce_in_deb2", st1, 1);
        rows = 4'b0000;
        step(3);
        chk("bounce_back_scan2", st1, 0);
        chk("bounce_no_valid", vc1 - base_v1, 0);
        rows = 4'b0100;
        wait_valid(n);
        chk("bounce_latency", n, 12);
        step(1);
        chk("bounce_valid_count", vc1 - base_v1, 1);
        rows = 4'b0000;
        wait_rel(n);
        chk("bounce_release", n, 11);

        // Chord on rows 0 and 1 is rejected
        base_v1 = vc1;
        wait_col(4'b0010);
        rows = 4'b0011;
        step(4);
        chk("ghost_state1", st1, 0);
        chk("ghost_rotate1", col1, 4'b0100);
        step(4);
        chk("ghost_state2", st1, 0);
        chk("ghost_rotate2", col1, 4'b1000);
        chk("ghost_row_kept", row1, 2);
        rows = 4'b0000;
        step(1);
        chk("ghost_no_valid", vc1 - base_v1, 0);

        // Auto-repeat over a 45-cycle hold on row 0 / column 0
        wait_col(4'b0001);
        base_v1 = vc1; base_v0 = vc0;
        rows = 4'b0001;
        wait_valid(n);
        chk("rep_latency", n, 12);
        chk("rep_first_norep", kv0, 1);
        chk("rep_first_flag", krp1, 0);
        chk("rep_row", row1, 0);
        chk("rep_col", kc1, 0);
        for (int h = 1; h <= 44; h++) begin
            @(negedge clk);
            exp_ev = (h == 20) || (h == 30) || (h == 40);
            chk($sformatf("rep_valid_h%0d", h), kv1, exp_ev);
            chk($sformatf("rep_flag_h%0d", h), krp1, exp_ev);
            chk($sformatf("norep_valid_h%0d", h), kv0, 0);
            if (h == 42) rows = 4'b0000;
        end
        step(1);
        chk("rep_released_state", st1, 3);
        chk("norep_released_state", st0, 3);
        wait_rel(n);
        chk("rep_release_latency", n, 8);
        chk("norep_release", krl0, 1);
        step(1);
        chk("rep_valid_count", vc1 - base_v1, 4);
        chk("norep_valid_count", vc0 - base_v0, 1);

        // Release glitch shorter than the debounce window
        wait_col(4'b0010);
        base_v1 = vc1; base_r1 = rc1;
        rows = 4'b0010;
        wait_valid(n);
        chk("glitch_latency", n, 12);
        chk("glitch_row", row1, 1);
        chk("glitch_col", kc1, 1);
        step(3);
        rows = 4'b0000;
        step(3);
        chk("glitch_in_release", st1, 3);
        chk("glitch_held_rel", kh1, 1);
        step(2);
        rows = 4'b0010;
        step(3);
        chk("glitch_back_hold", st1, 2);
        chk("glitch_held_hold", kh1, 1);
        step(5);
        chk("glitch_valid_count", vc1 - base_v1, 1);
        chk("glitch_no_release", rc1 - base_r1, 0);

        // Reset while in HOLD
        chk("rst_mid_pre", st1, 2);
        reset = 1'b1;
        rows  = 4'b0000;
        step(1);
        chk("rst_mid_state",   st1,  0);
        chk("rst_mid_col",     col1, 4'b0001);
        chk("rst_mid_valid",   kv1,  0);
        chk("rst_mid_release", krl1, 0);
        chk("rst_mid_held",    kh1,  0);
        chk("rst_mid_repeat",  krp1, 0);
        chk("rst_mid_row",     row1, 0);
        reset = 1'b0;
        base_r1 = rc1;
        step(20);
        chk("rst_mid_no_release", rc1 - base_r1, 0);
        chk("rst_mid_scan", st1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
